trace_player: RTL and testbench

Synthesizable playback source for time-stamped analog samples: the transmit-side counterpart of the waveform capture probe. A host or testbench loads a list of (timestamp, value) pairs, then, during emulation, the block presents each value on its output once the emulator time reaches that entry's timestamp. It sits next to the channel/filter path, where it can stand in for the filter output with a recorded or synthetic waveform. All arithmetic stays in the shared fixed-point formats.

---
 rtl/trace_player_pkg.sv | 34 +++
 rtl/trace_player_if.sv | 28 ++
 rtl/trace_player_fifo.sv | 87 ++++++++
 rtl/trace_player.sv | 170 +++++++++++++++++
 tb/tb_trace_player.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trace_player_pkg.sv
// trace_player_pkg
//   Shared fixed-point formats and types for the trace playback source.
//   TIME_FORMAT       : unsigned emulator timestamp, TIME_POINT fractional bits.
//   FILTER_OUT_FORMAT : signed sample value, FILTER_OUT_POINT fractional bits.
//   TRACE_ENTRY       : one stored (timestamp, value) pair.
//   PLAYER_STATE      : playback controller states.
package trace_player_pkg;

    localparam int TIME_WIDTH       = 32;
    localparam int TIME_POINT       = 16;
    localparam int FILTER_OUT_WIDTH = 16;
    localparam int FILTER_OUT_POINT = 8;

    typedef logic        [TIME_WIDTH-1:0]       TIME_FORMAT;
    typedef logic signed [FILTER_OUT_WIDTH-1:0] FILTER_OUT_FORMAT;

    typedef struct packed {
        TIME_FORMAT       t;
        FILTER_OUT_FORMAT v;
    } TRACE_ENTRY;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } PLAYER_STATE;

    // An entry is due once emulator time has reached its stamp.
    // Full-width unsigned compare, no wrap handling (time is monotonic).
    function automatic logic is_due(input TIME_FORMAT now, input TIME_FORMAT stamp);
        return now >= stamp;
    endfunction

endpackage

// File: rtl/trace_player_if.sv
// trace_player_if
//   Load bus for the trace buffer: valid/ready handshake carrying one
//   (timestamp, value) pair per accepted beat.
//   master : producer (host / testbench)
//   slave  : trace_player
interface trace_player_if;
    import trace_player_pkg::*;

    logic             wr_valid;
    logic             wr_ready;
    TIME_FORMAT       wr_time;
    FILTER_OUT_FORMAT wr_value;

    modport master (
        output wr_valid,
        output wr_time,
        output wr_value,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_time,
        input  wr_value,
        output wr_ready
    );

endinterface

// File: rtl/trace_player_fifo.sv
// trace_fifo
//   First-word fall-through buffer of TRACE_ENTRY. Storage is a register
//   array read combinationally at the read pointer, so a written entry is
//   visible at the head one cycle after its write.
//   Ports:
//     clk, rst_n     : clock, asynchronous active-low reset (pointers/count)
//     flush          : synchronous flush, overrides write and read
//     wr_en, wr_data : push (ignored when full)
//     rd_en          : pop the head (ignored when empty)
//     rd_data        : head entry
//     rd_next_time   : timestamp of the entry behind the head
//     full, empty, count
//   DEPTH must be a power of two and at least 2.
module trace_fifo
    import trace_player_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     wr_en,
    input  TRACE_ENTRY               wr_data,
    input  logic                     rd_en,
    output TRACE_ENTRY               rd_data,
    output TIME_FORMAT               rd_next_time,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    TRACE_ENTRY      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   rd_ptr_inc;
    logic [CW-1:0]   cnt;
    logic            wr_fire;
    logic            rd_fire;
    TRACE_ENTRY      next_entry;

    assign full       = (cnt == CW'(DEPTH));
    assign empty      = (cnt == '0);
    assign count      = cnt;
    assign wr_fire    = wr_en && !flush && !full;
    assign rd_fire    = rd_en && !flush && !empty;
    assign rd_ptr_inc = rd_ptr + AW'(1);

    assign rd_data      = mem[rd_ptr];
    assign next_entry   = mem[rd_ptr_inc];
    assign rd_next_time = next_entry.t;

    // Payload storage carries no reset; only entries that have been written
    // since the last flush/reset are ever consumed.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr_inc;
            end
            case ({wr_fire, rd_fire})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/trace_player.sv
// trace_player
//   Time-stamped sample playback source. Entries are loaded in
//   non-decreasing timestamp order while IDLE; after start, each entry is
//   presented on out_value once emu_time reaches its timestamp.
//   Ports:
//     clk, rst_n         : clock, asynchronous active-low reset
//     wr                 : load bus (trace_player_if.slave)
//     start, clear       : single-cycle control pulses
//     emu_time(_valid)   : current emulator time
//     out_value          : last played value (held)
//     out_update         : one-cycle pulse when out_value changes
//     busy, done         : state is PLAY / DONE
//     order_err, late    : sticky error flags
//     count              : entries currently stored
module trace_player
    import trace_player_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    trace_player_if.slave          wr,
    input  logic                   start,
    input  logic                   clear,
    input  TIME_FORMAT             emu_time,
    input  logic                   emu_time_valid,
    output FILTER_OUT_FORMAT       out_value,
    output logic                   out_update,
    output logic                   busy,
    output logic                   done,
    output logic                   order_err,
    output logic                   late,
    output logic [$clog2(DEPTH):0] count
);

    localparam int CW = $clog2(DEPTH) + 1;

    PLAYER_STATE      state;
    PLAYER_STATE      state_nxt;

    TRACE_ENTRY       wr_entry;
    TRACE_ENTRY       head;
    TIME_FORMAT       next_time;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;

    TIME_FORMAT       last_time;
    logic             load_fire;
    logic             stale;
    logic             push;

    logic             pop_p0;
    logic             next_due_p0;
    logic             last_pop_p0;

    FILTER_OUT_FORMAT value_p1;
    logic             vld_p1;
    logic             order_err_q;
    logic             late_q;

    assign wr_entry = '{t: wr.wr_time, v: wr.wr_value};

    trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (clear),
        .wr_en        (push),
        .wr_data      (wr_entry),
        .rd_en        (pop_p0),
        .rd_data      (head),
        .rd_next_time (next_time),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .count        (fifo_count)
    );

    assign wr.wr_ready = (state == IDLE) && !fifo_full;

    // An out-of-order entry still completes its handshake but is not
    // stored. last_time starts at zero, so nothing is stale until a load.
    assign load_fire = wr.wr_valid && wr.wr_ready && !clear;
    assign stale     = (wr.wr_time < last_time);
    assign push      = load_fire && !stale;

    // ---- stage p0: pop decision against the registered head ----
    assign pop_p0      = (state == PLAY) && !fifo_empty && !clear &&
                         emu_time_valid && is_due(emu_time, head.t);
    assign next_due_p0 = (fifo_count > CW'(1)) && is_due(emu_time, next_time);
    assign last_pop_p0 = pop_p0 && (fifo_count == CW'(1));

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = fifo_empty ? DONE : PLAY;
                    end
                end
                PLAY: begin
                    if (last_pop_p0) begin
                        state_nxt = DONE;
                    end
                end
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_time   <= '0;
            order_err_q <= 1'b0;
            late_q      <= 1'b0;
        end else if (clear) begin
            last_time   <= '0;
            order_err_q <= 1'b0;
            late_q      <= 1'b0;
        end else begin
            if (push) begin
                last_time <= wr.wr_time;
            end
            if (load_fire && stale) begin
                order_err_q <= 1'b1;
            end
            if (pop_p0 && next_due_p0) begin
                late_q <= 1'b1;
            end
        end
    end

    // ---- stage p1: output register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_p1 <= '0;
            vld_p1   <= 1'b0;
        end else if (clear) begin
            value_p1 <= '0;
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= pop_p0;
            if (pop_p0) begin
                value_p1 <= head.v;
            end
        end
    end

    assign out_value  = value_p1;
    assign out_update = vld_p1;
    assign busy       = (state == PLAY);
    assign done       = (state == DONE);
    assign order_err  = order_err_q;
    assign late       = late_q;
    assign count      = fifo_count;

endmodule

// File: tb/tb_trace_player.sv
module tb_trace_player;
    import trace_player_pkg::*;

    localparam int DEPTH = 64;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             clear = 1'b0;
    TIME_FORMAT       emu_time = '0;
    logic             emu_time_valid = 1'b0;
    FILTER_OUT_FORMAT out_value;
    logic             out_update;
    logic             busy;
    logic             done;
    logic             order_err;
    logic             late;
    logic [6:0]       count;

    trace_player_if ld();

    trace_player #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr             (ld),
        .start          (start),
        .clear          (clear),
        .emu_time       (emu_time),
        .emu_time_valid (emu_time_valid),
        .out_value      (out_value),
        .out_update     (out_update),
        .busy           (busy),
        .done           (done),
        .order_err      (order_err),
        .late           (late),
        .count          (count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The buffer is a queue; playback is "not started", "playing" or "finished".
    TRACE_ENTRY       mq[$];
    TIME_FORMAT       m_last = '0;
    FILTER_OUT_FORMAT m_out  = '0;
    bit               m_upd  = 0;
    bit               m_oerr = 0;
    bit               m_late = 0;
    bit               m_play = 0;
    bit               m_done = 0;

    function automatic void m_reset();
        mq.delete();
        m_last = '0; m_out = '0; m_upd = 0;
        m_oerr = 0; m_late = 0; m_play = 0; m_done = 0;
    endfunction

    function automatic void m_step();
        int sz;
        bit idle;
        sz   = mq.size();
        idle = !m_play && !m_done;
        m_upd = 0;
        if (clear) begin
            m_reset();
        end else if (idle) begin
            if (ld.wr_valid && sz < DEPTH) begin
                if (ld.wr_time < m_last) m_oerr = 1;
                else begin
                    mq.push_back('{t: ld.wr_time, v: ld.wr_value});
                    m_last = ld.wr_time;
                end
            end
            if (start) begin
                if (sz > 0) m_play = 1;
                else        m_done = 1;
            end
        end else if (m_play) begin
            if (emu_time_valid && sz > 0 && emu_time >= mq[0].t) begin
                if (sz > 1 && mq[1].t <= emu_time) m_late = 1;
                m_out = mq[0].v;
                void'(mq.pop_front());
                m_upd = 1;
                if (mq.size() == 0) begin
                    m_play = 0;
                    m_done = 1;
                end
            end
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_reset();
        else        m_step();
    end

    always @(negedge clk) begin
        check("out_value",  out_value,   m_out);
        check("out_update", out_update,  m_upd);
        check("busy",       busy,        m_play);
        check("done",       done,        m_done);
        check("order_err",  order_err,   m_oerr);
        check("late",       late,        m_late);
        check("count",      count,       mq.size());
        check("wr_ready",   ld.wr_ready, (!m_play && !m_done && mq.size() < DEPTH));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int t, input int v);
        ld.wr_valid = 1'b1;
        ld.wr_time  = TIME_FORMAT'(t);
        ld.wr_value = FILTER_OUT_FORMAT'(v);
        tick();
        ld.wr_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".out_value"},  out_value,   0);
        check({tag, ".out_update"}, out_update,  0);
        check({tag, ".busy"},       busy,        0);
        check({tag, ".done"},       done,        0);
        check({tag, ".order_err"},  order_err,   0);
        check({tag, ".late"},       late,        0);
        check({tag, ".count"},      count,       0);
        check({tag, ".wr_ready"},   ld.wr_ready, 1);
    endtask

    int npulse;
    int pulse_at [4];
    int pulse_val[4];
    int accepted;
    bit finished;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ld.wr_valid = 1'b0;
        ld.wr_time  = '0;
        ld.wr_value = '0;
        tick();
        check_reset_outputs("reset");
        tick();
        rst_n = 1'b1;
        tick();

        // Test 1: spaced entries, emu_time ramps by one per cycle.
        load(100, 5);
        load(200, -3);
        load(300, 7);
        check("t1.count", count, 3);
        emu_time_valid = 1'b1;
        emu_time = '0;
        pulse_start();
        check("t1.busy", busy, 1);
        npulse = 0;
        for (int t = 0; t <= 310; t++) begin
            emu_time = TIME_FORMAT'(t);
            tick();
            if (out_update) begin
                if (npulse < 4) begin
                    pulse_at[npulse]  = t;
                    pulse_val[npulse] = int'(out_value);
                end
                npulse++;
            end
        end
        check("t1.pulses", npulse, 3);
        check("t1.at0", pulse_at[0], 100);
        check("t1.at1", pulse_at[1], 200);
        check("t1.at2", pulse_at[2], 300);
        check("t1.val0", pulse_val[0], 5);
        check("t1.val1", pulse_val[1], -3);
        check("t1.val2", pulse_val[2], 7);
        check("t1.done", done, 1);
        check("t1.late", late, 0);

        // Test 2: three entries all due at once -> back-to-back pops, late.
        pulse_clear();
        emu_time = TIME_FORMAT'(60);
        load(50, 1);
        load(50, 2);
        load(50, 3);
        pulse_start();
        npulse = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_update) begin
                if (npulse < 4) begin
                    pulse_at[npulse]  = i;
                    pulse_val[npulse] = int'(out_value);
                end
                npulse++;
            end
        end
        check("t2.pulses", npulse, 3);
        check("t2.at0", pulse_at[0], 0);
        check("t2.at2", pulse_at[2], 2);
        check("t2.val0", pulse_val[0], 1);
        check("t2.val1", pulse_val[1], 2);
        check("t2.val2", pulse_val[2], 3);
        check("t2.late", late, 1);
        check("t2.done", done, 1);

        // Test 3: out-of-order load is dropped.
        pulse_clear();
        load(200, 1);
        load(150, 2);
        check("t3.order_err", order_err, 1);
        check("t3.count", count, 1);

        // Test 4: fill to DEPTH with valid held; 65th+ not taken; play out.
        pulse_clear();
        accepted = 0;
        ld.wr_valid = 1'b1;
        for (int i = 0; i < 70; i++) begin
            ld.wr_time  = TIME_FORMAT'(i);
            ld.wr_value = FILTER_OUT_FORMAT'(i);
            if (ld.wr_ready) accepted++;
            tick();
        end
        ld.wr_valid = 1'b0;
        check("t4.accepted", accepted, DEPTH);
        check("t4.count", count, DEPTH);
        check("t4.wr_ready", ld.wr_ready, 0);
        emu_time = TIME_FORMAT'(100000);
        pulse_start();
        finished = 0;
        for (int i = 0; i < 100 && !finished; i++) begin
            tick();
            if (done) finished = 1;
        end
        check("t4.done_in_budget", finished, 1);
        check("t4.count_end", count, 0);
        check("t4.last_value", out_value, DEPTH - 1);

        // Test 5: start with an empty buffer.
        pulse_clear();
        pulse_start();
        check("t5.done", done, 1);
        check("t5.busy", busy, 0);
        check("t5.out_update", out_update, 0);

        // Test 6a: asynchronous reset during PLAY after two pops.
        pulse_clear();
        load(10, 1);
        load(20, 2);
        load(30, 3);
        emu_time = TIME_FORMAT'(25);
        pulse_start();
        tick();
        tick();
        check("t6a.count_before", count, 1);
        check("t6a.value_before", out_value, 2);
        check("t6a.late_before", late, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6a");
        tick();
        rst_n = 1'b1;
        tick();
        load(5, 9);
        check("t6a.reload_count", count, 1);
        check("t6a.reload_oerr", order_err, 0);

        // Test 6b: clear during PLAY.
        pulse_clear();
        emu_time_valid = 1'b0;
        load(10, 1);
        load(20, 2);
        pulse_start();
        emu_time_valid = 1'b1;
        emu_time = TIME_FORMAT'(15);
        tick();
        check("t6b.value_before", out_value, 1);
        check("t6b.busy_before", busy, 1);
        pulse_clear();
        check_reset_outputs("t6b");
        load(1, 4);
        check("t6b.reload_count", count, 1);
        check("t6b.reload_oerr", order_err, 0);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
